// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff_o = a_i - b_i, DIGIT bits per cycle, LSB digit first.
// Optional macro SERIAL_SUBTRACTOR_SATURATE_EN clamps diff_o to 0 when the final borrow is set.
//
// state  | meaning
// IDLE   | ready_o high, waiting for an operand handshake
// BUSY   | one digit subtracted per edge, K edges total
// DONE   | valid_o high, result held until ready_i
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    localparam int K     = WIDTH / DIGIT;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             res_borrow_q, res_borrow_d;

    int               dig_lsb;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   digit_sub;

    // Extra top bit of digit_sub captures the borrow out of this digit.
    always_comb begin
        dig_lsb   = int'(cnt_q) * DIGIT;
        a_dig     = a_q[dig_lsb +: DIGIT];
        b_dig     = b_q[dig_lsb +: DIGIT];
        digit_sub = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_q};
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        work_d       = work_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        res_borrow_d = res_borrow_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                work_d[dig_lsb +: DIGIT] = digit_sub[DIGIT-1:0];
                borrow_d                 = digit_sub[DIGIT];
                cnt_d                    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    state_d      = S_DONE;
                    res_borrow_d = digit_sub[DIGIT];
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
                    diff_d = digit_sub[DIGIT] ? '0 : work_d;
`else
                    diff_d = work_d;
`endif
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            work_q       <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            res_borrow_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            work_q       <= work_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            res_borrow_q <= res_borrow_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign diff_o   = diff_q;
    assign borrow_o = res_borrow_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter DIGIT, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT; K = WIDTH/DIGIT.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  operands a_i/b_i valid.
REQ-006 SHALL have port ready_o  output  1  block can accept operands.
REQ-007 SHALL have port a_i  input  WIDTH  minuend, unsigned.
REQ-008 SHALL have port b_i  input  WIDTH  subtrahend, unsigned.
REQ-009 SHALL have port valid_o  output  1  diff_o/borrow_o valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts result.
REQ-011 SHALL have port diff_o  output  WIDTH  result a - b.
REQ-012 SHALL have port borrow_o  output  1  final borrow, 1 iff a < b unsigned.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY, DONE; ready_o = 1 only in IDLE, valid_o = 1 only in DONE.
REQ-014 IDLE: on an edge with valid_i && ready_o, SHALL latch a_i, b_i, clear internal borrow and digit counter, go to BUSY.
REQ-015 BUSY: each edge SHALL subtract digit i (bits i*DIGIT+DIGIT-1 : i*DIGIT, LSB digit first) as a - b - borrow_in, store the DIGIT-bit result into the same digit position of the result register, update borrow, increment counter.
REQ-016 BUSY SHALL last exactly K edges; on the K-th edge state SHALL become DONE, so valid_o rises K edges after the accepting edge (4 for defaults).
REQ-017 DONE: diff_o and borrow_o SHALL be held stable until an edge with valid_o && ready_i, after which state SHALL be IDLE and valid_o = 0.
REQ-018 valid_i SHALL be ignored in BUSY and DONE; a_i/b_i changes after acceptance SHALL NOT affect the result.
REQ-019 Without saturation (see Configuration), diff_o SHALL equal (a - b) mod 2^WIDTH.
REQ-020 A new operation SHALL be accepted no earlier than the cycle after the output handshake; minimum period K+2 cycles.
REQ-021 diff_o and borrow_o outside DONE SHALL retain the last completed result (0 after reset).

Reset
REQ-022 rst_i high at an edge SHALL force IDLE, counter 0, internal borrow 0, valid_o = 0, ready_o = 1, diff_o = 0, borrow_o = 0.
REQ-023 Reset SHALL take priority over any handshake in the same cycle and SHALL abort a BUSY or DONE operation with no result emitted.

Configuration
REQ-024 Macro SERIAL_SUBTRACTOR_SATURATE_EN: when defined, if the final borrow is 1 the DONE-state diff_o SHALL be 0 (borrow_o still 1); when undefined, diff_o SHALL be the wrapped value per REQ-019.

Verification (WIDTH=32, DIGIT=8)
REQ-025 a=0x00000010, b=0x00000003 accepted at edge E0 -> valid_o at E4, diff_o=0x0000000D, borrow_o=0.
REQ-026 a=0x00000000, b=0x00000001 -> macro undefined: diff_o=0xFFFFFFFF, borrow_o=1; macro defined: diff_o=0x00000000, borrow_o=1.
REQ-027 Cross-digit borrow a=0x00010000, b=0x00000001 -> diff_o=0x0000FFFF, borrow_o=0.
REQ-028 Backpressure: ready_i=0 for 10 cycles in DONE, valid_i pulsed with a=5, b=1 -> valid_o, diff_o, borrow_o unchanged, ready_o=0, pulse ignored; ready_i=1 -> IDLE next cycle.
REQ-029 rst_i asserted for one edge during 2nd BUSY cycle -> next cycle IDLE, ready_o=1, valid_o=0, diff_o=0; subsequent a=7, b=9 yields diff_o=0xFFFFFFFE, borrow_o=1 (macro undefined).
REQ-030 Back-to-back: valid_i held high with two operand pairs, ready_i=1 -> second accepted exactly one cycle after first output handshake, both results correct, period K+2=6 cycles.
